// File: rtl/cache_pkg.sv
// Shared cache geometry and refill state encoding.
// The lookup path imports the same widths.
package cache_pkg;

    localparam int INDEX_BITS  = $clog2(256);
    localparam int OFFSET_BITS = $clog2(64);
    localparam int LINE_BITS   = 8 * 64;
    localparam int BEATS       = LINE_BITS / 32;
    localparam int ADDR_BITS   = 18 + INDEX_BITS + OFFSET_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_REQ,
        ST_WB_DATA,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_FILL
    } refill_state_e;

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage: whole-line load, beat-indexed
// write for incoming reads, beat-indexed read for write-back.
module line_beat_buffer #(
    parameter int  LINE_BITS  = 512,
    parameter int  DATA_WIDTH = 32,
    localparam int BEATS      = LINE_BITS / DATA_WIDTH,
    localparam int BEAT_W     = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LINE_BITS-1:0]  load_line,
    input  logic                  wr_en,
    input  logic [BEAT_W-1:0]     beat,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LINE_BITS-1:0]  line
);

    logic [LINE_BITS-1:0] line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (wr_en) begin
            line_q[int'(beat) * DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        end
    end

    assign rd_data = line_q[int'(beat) * DATA_WIDTH +: DATA_WIDTH];
    assign line    = line_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss handler: victim write-back, beat-wise line fetch, array fill.
// Owns the write port of the tag/data array read by the lookup stage.
module cache_refill_ctrl #(
    parameter int  CACHE_LINES     = 256,
    parameter int  LINE_SIZE_BYTES = 64,
    parameter int  TAG_BITS        = 18,
    parameter int  DATA_WIDTH      = 32,
    parameter int  WAYS            = 4,
    localparam int IDX_W  = $clog2(CACHE_LINES),
    localparam int OFF_W  = $clog2(LINE_SIZE_BYTES),
    localparam int LINE_W = 8 * LINE_SIZE_BYTES,
    localparam int NBEATS = LINE_W / DATA_WIDTH,
    localparam int ADDR_W = TAG_BITS + IDX_W + OFF_W,
    localparam int WAY_W  = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss_valid,
    output logic                  o_miss_ready,
    input  logic [TAG_BITS-1:0]   i_miss_tag,
    input  logic [IDX_W-1:0]      i_miss_index,
    input  logic [WAY_W-1:0]      i_victim_way,
    input  logic                  i_victim_valid,
    input  logic                  i_victim_dirty,
    input  logic [TAG_BITS-1:0]   i_victim_tag,
    input  logic [LINE_W-1:0]     i_victim_line,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_we,
    output logic [ADDR_W-1:0]     o_mem_req_addr,
    output logic                  o_mem_wvalid,
    input  logic                  i_mem_wready,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_fill_we,
    output logic [IDX_W-1:0]      o_fill_index,
    output logic [WAY_W-1:0]      o_fill_way,
    output logic [TAG_BITS-1:0]   o_fill_tag,
    output logic [LINE_W-1:0]     o_fill_line,
    output logic                  o_done
);

    import cache_pkg::*;

    localparam int             CNT_W = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBEATS - 1);

    refill_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TAG_BITS-1:0]   tag_q, vtag_q;
    logic [IDX_W-1:0]      index_q;
    logic [WAY_W-1:0]      way_q;
    logic                  accept;
    logic                  buf_wr;
    logic [DATA_WIDTH-1:0] buf_rdata;

    assign accept = (state_q == ST_IDLE) && i_miss_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            index_q <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                tag_q   <= i_miss_tag;
                vtag_q  <= i_victim_tag;
                index_q <= i_miss_index;
                way_q   <= i_victim_way;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        o_miss_ready    = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_req_we    = 1'b0;
        o_mem_req_addr  = '0;
        o_mem_wvalid    = 1'b0;
        o_mem_wdata     = '0;
        o_fill_we       = 1'b0;
        o_done          = 1'b0;
        buf_wr          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_miss_ready = 1'b1;
                if (i_miss_valid) begin
                    state_d = (i_victim_valid && i_victim_dirty)
                            ? ST_WB_REQ : ST_RD_REQ;
                end
            end
            ST_WB_REQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_we    = 1'b1;
                o_mem_req_addr  = {vtag_q, index_q, {OFF_W{1'b0}}};
                if (i_mem_req_ready) begin
                    state_d = ST_WB_DATA;
                    cnt_d   = '0;
                end
            end
            ST_WB_DATA: begin
                o_mem_wvalid = 1'b1;
                o_mem_wdata  = buf_rdata;
                if (i_mem_wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = {tag_q, index_q, {OFF_W{1'b0}}};
                if (i_mem_req_ready) begin
                    state_d = ST_RD_DATA;
                    cnt_d   = '0;
                end
            end
            ST_RD_DATA: begin
                if (i_mem_rvalid) begin
                    buf_wr = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                o_fill_we = 1'b1;
                o_done    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Victim line is loaded at accept; read beats then overwrite it in place.
    line_beat_buffer #(
        .LINE_BITS (LINE_W),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_line(i_victim_line),
        .wr_en    (buf_wr),
        .beat     (cnt_q),
        .wr_data  (i_mem_rdata),
        .rd_data  (buf_rdata),
        .line     (o_fill_line)
    );

    assign o_fill_index = index_q;
    assign o_fill_way   = way_q;
    assign o_fill_tag   = tag_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: a transaction-level model
// predicts each memory phase, its cycle, and the filled line.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

    typedef logic [511:0] line_t;
    typedef struct {
        logic [17:0] tag;
        logic [7:0]  idx;
        logic [1:0]  way;
        logic        vv;
        logic        vd;
        logic [17:0] vtag;
        line_t       vline;
    } miss_t;

    localparam int P_WBREQ  = 0;
    localparam int P_WBDATA = 1;
    localparam int P_RDREQ  = 2;
    localparam int P_RDDATA = 3;
    localparam int P_FILL   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss_valid, o_miss_ready;
    logic [17:0] i_miss_tag;
    logic [7:0]  i_miss_index;
    logic [1:0]  i_victim_way;
    logic        i_victim_valid, i_victim_dirty;
    logic [17:0] i_victim_tag;
    line_t       i_victim_line;
    logic        o_mem_req_valid, i_mem_req_ready, o_mem_req_we;
    logic [31:0] o_mem_req_addr;
    logic        o_mem_wvalid, i_mem_wready;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_fill_we, o_done;
    logic [7:0]  o_fill_index;
    logic [1:0]  o_fill_way;
    logic [17:0] o_fill_tag;
    line_t       o_fill_line;

    int n_chk  = 0;
    int n_fail = 0;

    cache_refill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss_valid   (i_miss_valid),
        .o_miss_ready   (o_miss_ready),
        .i_miss_tag     (i_miss_tag),
        .i_miss_index   (i_miss_index),
        .i_victim_way   (i_victim_way),
        .i_victim_valid (i_victim_valid),
        .i_victim_dirty (i_victim_dirty),
        .i_victim_tag   (i_victim_tag),
        .i_victim_line  (i_victim_line),
        .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_we   (o_mem_req_we),
        .o_mem_req_addr (o_mem_req_addr),
        .o_mem_wvalid   (o_mem_wvalid),
        .i_mem_wready   (i_mem_wready),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rvalid   (i_mem_rvalid),
        .i_mem_rdata    (i_mem_rdata),
        .o_fill_we      (o_fill_we),
        .o_fill_index   (o_fill_index),
        .o_fill_way     (o_fill_way),
        .o_fill_tag     (o_fill_tag),
        .o_fill_line    (o_fill_line),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input line_t got, input line_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic line_t seq_line(input int base);
        line_t l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'(base + k);
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic miss_t mk(input logic [17:0] tag, input logic [7:0] idx,
                                 input logic [1:0] way, input logic vv,
                                 input logic vd, input logic [17:0] vtag,
                                 input line_t vl);
        miss_t m;
        m.tag = tag; m.idx = idx; m.way = way;
        m.vv = vv; m.vd = vd; m.vtag = vtag; m.vline = vl;
        return m;
    endfunction

    function automatic miss_t rand_miss(input bit dirty);
        return mk(18'($urandom), 8'($urandom), 2'($urandom),
                  dirty | 1'($urandom), dirty, 18'($urandom), rand_line());
    endfunction

    function automatic bit req_rdy(input int mode, input int stall);
        if (mode == 0) return 1'b1;
        if (mode == 1) return stall >= 5;
        return $urandom_range(0, 3) == 0;
    endfunction

    function automatic bit dat_rdy(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (n % 2) == 0;
        return 1'($urandom);
    endfunction

    task automatic drive_miss(input miss_t m);
        i_miss_tag     = m.tag;
        i_miss_index   = m.idx;
        i_victim_way   = m.way;
        i_victim_valid = m.vv;
        i_victim_dirty = m.vd;
        i_victim_tag   = m.vtag;
        i_victim_line  = m.vline;
    endtask

    task automatic quiet_mem();
        i_mem_req_ready = 1'b0;
        i_mem_wready    = 1'b0;
        i_mem_rvalid    = 1'b0;
        i_mem_rdata     = '0;
    endtask

    task automatic do_miss(input miss_t m, input int mode, input bit strays,
                           input bit hold, input miss_t nxt,
                           input int rbase, input int abort_beat);
        line_t       exp_line = '0;
        logic [31:0] wb_addr, rd_addr;
        bit          wb, fin = 1'b0;
        int          ph, k = 0, n = 0, stall = 0;
        logic [31:0] d;
        wb      = m.vv && m.vd;
        wb_addr = {m.vtag, m.idx, 6'b0};
        rd_addr = {m.tag, m.idx, 6'b0};
        ph      = wb ? P_WBREQ : P_RDREQ;
        @(negedge clk);
        chk("ready_idle", o_miss_ready, 1);
        drive_miss(m);
        i_miss_valid    = 1'b1;
        i_mem_req_ready = 1'b0;
        i_mem_wready    = strays;
        i_mem_rvalid    = strays;
        i_mem_rdata     = $urandom;
        while (!fin && n < 600) begin
            @(negedge clk);
            n++;
            i_miss_valid = 1'b0;
            quiet_mem();
            chk("ready_busy", o_miss_ready, 0);
            if (ph != P_FILL) chk("fill_early", o_fill_we, 0);
            case (ph)
                P_WBREQ: begin
                    chk("wb_req_valid", o_mem_req_valid, 1);
                    chk("wb_req_we", o_mem_req_we, 1);
                    chk("wb_req_addr", o_mem_req_addr, wb_addr);
                    i_mem_req_ready = req_rdy(mode, stall);
                    stall++;
                    if (i_mem_req_ready) begin ph = P_WBDATA; k = 0; end
                end
                P_WBDATA: begin
                    chk("wvalid", o_mem_wvalid, 1);
                    chk("wb_no_req", o_mem_req_valid, 0);
                    chk("wdata", o_mem_wdata, m.vline[k*32 +: 32]);
                    i_mem_wready = dat_rdy(mode, n);
                    if (strays) begin
                        i_mem_rvalid = 1'($urandom);
                        i_mem_rdata  = $urandom;
                    end
                    if (i_mem_wready) begin
                        k++;
                        if (k == 16) begin ph = P_RDREQ; stall = 0; end
                    end
                end
                P_RDREQ: begin
                    chk("rd_req_valid", o_mem_req_valid, 1);
                    chk("rd_req_we", o_mem_req_we, 0);
                    chk("rd_req_addr", o_mem_req_addr, rd_addr);
                    chk("rd_no_wvalid", o_mem_wvalid, 0);
                    i_mem_req_ready = req_rdy(mode, stall);
                    stall++;
                    if (i_mem_req_ready) begin ph = P_RDDATA; k = 0; end
                end
                P_RDDATA: begin
                    chk("rd_no_req", o_mem_req_valid, 0);
                    chk("rd_no_wvalid", o_mem_wvalid, 0);
                    if (k == abort_beat) begin
                        rst = 1'b0;
                        #1;
                        chk("rst_ready", o_miss_ready, 1);
                        chk("rst_req", o_mem_req_valid, 0);
                        chk("rst_fill_we", o_fill_we, 0);
                        chk("rst_done", o_done, 0);
                        chk("rst_line", o_fill_line, 0);
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata  = $urandom;
                        repeat (3) begin
                            @(negedge clk);
                            chk("rst_hold_fill", o_fill_we, 0);
                        end
                        rst = 1'b1;
                        repeat (20) begin
                            @(negedge clk);
                            chk("post_rst_fill", o_fill_we, 0);
                            chk("post_rst_req", o_mem_req_valid, 0);
                        end
                        i_mem_rvalid = 1'b0;
                        fin = 1'b1;
                    end else begin
                        i_mem_rvalid = dat_rdy(mode, n);
                        d = (rbase != 0) ? 32'(rbase + k) : $urandom;
                        i_mem_rdata = d;
                        if (strays) begin
                            i_miss_valid = 1'b1;
                            i_miss_tag   = 18'($urandom);
                        end
                        if (i_mem_rvalid) begin
                            exp_line[k*32 +: 32] = d;
                            k++;
                            if (k == 16) ph = P_FILL;
                        end
                    end
                end
                default: begin
                    chk("fill_we", o_fill_we, 1);
                    chk("done", o_done, 1);
                    chk("fill_way", o_fill_way, m.way);
                    chk("fill_tag", o_fill_tag, m.tag);
                    chk("fill_index", o_fill_index, m.idx);
                    chk("fill_line", o_fill_line, exp_line);
                    if (mode == 0) chk("fill_latency", n, wb ? 35 : 18);
                    if (hold) drive_miss(nxt);
                    i_miss_valid = hold;
                    fin = 1'b1;
                end
            endcase
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        miss_t a, b;
        rst          = 1'b0;
        i_miss_valid = 1'b0;
        drive_miss(mk('0, '0, '0, 1'b0, 1'b0, '0, '0));
        quiet_mem();
        repeat (2) @(negedge clk);
        chk("reset_ready", o_miss_ready, 1);
        chk("reset_req", o_mem_req_valid, 0);
        chk("reset_wvalid", o_mem_wvalid, 0);
        chk("reset_fill_we", o_fill_we, 0);
        chk("reset_done", o_done, 0);
        chk("reset_addr", o_mem_req_addr, 0);
        chk("reset_line", o_fill_line, 0);
        rst = 1'b1;

        a = mk(18'h12345, 8'h3A, 2'd2, 1'b0, 1'b0, 18'h0, rand_line());
        do_miss(a, 0, 1'b0, 1'b0, a, 32'h1000, -1);

        a = mk(18'h12345, 8'h3A, 2'd1, 1'b1, 1'b1, 18'h00ABC,
               seq_line(32'hD000));
        do_miss(a, 0, 1'b0, 1'b0, a, 32'h2000, -1);

        a = rand_miss(1'b1);
        do_miss(a, 1, 1'b1, 1'b0, a, 0, -1);

        a = rand_miss(1'b0);
        a.vv = 1'b0;
        do_miss(a, 0, 1'b0, 1'b0, a, 32'h3000, 7);

        a = rand_miss(1'b0);
        a.vv = 1'b0;
        do_miss(a, 0, 1'b0, 1'b0, a, 0, -1);

        a = rand_miss(1'b0);
        b = rand_miss(1'b1);
        do_miss(a, 0, 1'b0, 1'b1, b, 0, -1);
        do_miss(b, 0, 1'b0, 1'b0, b, 0, -1);

        for (int i = 0; i < 12; i++) begin
            a = rand_miss(1'($urandom));
            do_miss(a, 2, 1'($urandom), 1'b0, a, 0, -1);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
